// File: rtl/aes_enc_pkg.sv
// Shared types for the AES encryption round datapath.
package aes_enc_pkg;

  localparam int AES_NB = 4;

  typedef logic [7:0]     byte_t;
  typedef byte_t [3:0]    row_t;
  typedef byte_t [15:0]   state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } shr_state_e;

endpackage

// File: rtl/mod_enc_shifter.sv
// Single-row rotator. Each write rotates one 4-byte row left by the internal
// row index, then advances that index, so four writes cover rows 0..3.
module mod_enc_shifter #(
  parameter int NB = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wr_en,
  input  logic [NB-1:0][7:0] inp,
  output logic [NB-1:0][7:0] outp,
  output logic               done
);

  logic [1:0] r_q;

  // Rotate the written row by r, flag the row-3 result, and step r.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q  <= '0;
      outp <= '0;
      done <= 1'b0;
    end else begin
      done <= wr_en && (r_q == 2'd3);
      if (wr_en) begin
        for (int i = 0; i < NB; i++)
          outp[i] <= inp[2'(i) + r_q];
        r_q <= r_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mod_enc_shiftrows_ctrl.sv
// ShiftRows sequencer: streams the four rows of a latched state through one
// shifter, reassembles the rotated rows, and presents the result with a
// valid/ready handshake. Byte layout is column-major, k = 4*col + row, so a
// byte index is simply {col, row}.
module mod_enc_shiftrows_ctrl
  import aes_enc_pkg::*;
#(
  parameter int NB = AES_NB
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NB*NB-1:0][7:0] inp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NB*NB-1:0][7:0] outp,
  output logic                  busy,
  output logic                  err
);

  shr_state_e state_q, state_d;

  logic [NB*NB-1:0][7:0] st_q;
  logic [NB*NB-1:0][7:0] res_q;
  logic [1:0]            wr_row;
  logic [1:0]            rd_row;
  logic                  cap_q;
  logic                  feed_wr;
  logic                  sh_wr_en;
  logic [NB-1:0][7:0]    sh_inp;
  logic [NB-1:0][7:0]    sh_outp;
  logic                  sh_done;
  logic                  accept;
  logic                  capture;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    feed_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = FEED;
      end
      FEED: begin
        feed_wr = 1'b1;
        if (wr_row == 2'd3) state_d = DRAIN;
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = in_ready && in_valid;
  assign sh_wr_en = feed_wr;
  // A capture is only meaningful for writes this controller issued.
  assign capture  = cap_q && ((state_q == FEED) || (state_q == DRAIN));
  assign outp     = res_q;

  // Gather row wr_row from the latched state: byte of column i.
  always_comb begin
    for (int i = 0; i < NB; i++)
      sh_inp[i] = st_q[{2'(i), wr_row}];
  end

  mod_enc_shifter #(.NB(NB)) u_shifter (
    .clk    (clk),
    .resetn (resetn),
    .wr_en  (sh_wr_en),
    .inp    (sh_inp),
    .outp   (sh_outp),
    .done   (sh_done)
  );

  // Latch the input state on accept and walk the write row through FEED.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= '0;
      wr_row <= '0;
    end else if (accept) begin
      st_q   <= inp;
      wr_row <= '0;
    end else if (feed_wr) begin
      wr_row <= wr_row + 2'd1;
    end
  end

  // Scatter each shifter result back into its row, one cycle behind the
  // write, and flag any disagreement between shifter done and row 3.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_q  <= 1'b0;
      res_q  <= '0;
      rd_row <= '0;
      err    <= 1'b0;
    end else begin
      cap_q <= sh_wr_en;
      if (accept) begin
        rd_row <= '0;
      end else if (capture) begin
        for (int i = 0; i < NB; i++)
          res_q[{2'(i), rd_row}] <= sh_outp[i];
        rd_row <= rd_row + 2'd1;
        if (sh_done != (rd_row == 2'd3)) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_enc_shiftrows_ctrl.sv
// Bench for the ShiftRows sequencer: a transaction-level model predicts
// accept/valid timing and the shifted state; one negedge process compares.
module tb_mod_enc_shiftrows_ctrl;
  import aes_enc_pkg::*;

  logic   clk = 1'b0;
  logic   resetn = 1'b1;
  logic   in_valid = 1'b0;
  logic   out_ready = 1'b1;
  state_t inp = '0;
  logic   in_ready, out_valid, busy, err;
  state_t outp;

  always #5 clk = ~clk;

  mod_enc_shiftrows_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .busy      (busy),
    .err       (err)
  );

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  state_t expq[$];
  logic   pending = 1'b0;
  int     acc_cyc = 0;
  logic   data_chk = 1'b1;
  int     wr_cnt = 0;
  state_t last_out = '0;
  int     stall_cnt = 0;
  logic   rand_rdy = 1'b0;
  logic   ov_exp;

  localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_OUT  = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  // AES ShiftRows: row r rotates left by r columns.
  function automatic state_t shift_rows(state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4*c + r] = s[4*((c + r) % 4) + r];
    return o;
  endfunction

  // Byte k of the state is the k-th byte of the literal as written.
  function automatic state_t mk(logic [127:0] v);
    state_t s;
    for (int k = 0; k < 16; k++)
      s[k] = v[127 - 8*k -: 8];
    return s;
  endfunction

  function automatic state_t rnd_state();
    return state_t'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chkb(string nm, logic got, logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic chki(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream: scripted stalls, random back-pressure, or always ready.
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0 && out_valid) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (rand_rdy) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  // Model: one state in flight; output valid from 6 cycles after accept
  // until the handshake; ready and busy follow occupancy.
  always @(negedge clk) begin
    if (!resetn) begin
      pending = 1'b0;
      expq.delete();
    end else begin
      ov_exp = pending && (cyc - acc_cyc >= 6);
      chkb("in_ready", in_ready, !pending);
      chkb("busy", busy, pending);
      chkb("out_valid", out_valid, ov_exp);
      if (dut.sh_wr_en) wr_cnt++;
      if (ov_exp) begin
        if (data_chk && expq.size() > 0) chk("outp", outp, expq[0]);
        if (out_ready) begin
          last_out = outp;
          if (expq.size() > 0) void'(expq.pop_front());
          pending = 1'b0;
        end
      end else if (!pending && in_valid) begin
        expq.push_back(shift_rows(inp));
        pending = 1'b1;
        acc_cyc = cyc;
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(state_t s);
    int n = 0;
    inp = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chkb("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inp = rnd_state();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pending && n < 200) begin
      @(negedge clk);
      n++;
    end
    chkb("drain_timeout", pending, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(string tag);
    chkb({tag, "_in_ready"}, in_ready, 1'b1);
    chkb({tag, "_out_valid"}, out_valid, 1'b0);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_err"}, err, 1'b0);
    chk({tag, "_outp"}, outp, '0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    state_t a, b, c;
    #2 resetn = 1'b0;
    #1 reset_checks("rst");
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    step(1);

    // Pin the model to known answers.
    chk("model_seq", shift_rows(mk(SEQ_IN)), mk(SEQ_OUT));
    chk("model_fips", shift_rows(mk(FIPS_IN)), mk(FIPS_OUT));

    // Sequential byte pattern and FIPS-197 round vector.
    send(mk(SEQ_IN));
    wait_idle();
    chk("seq_out", last_out, mk(SEQ_OUT));
    send(mk(FIPS_IN));
    wait_idle();
    chk("fips_out", last_out, mk(FIPS_OUT));
    chkb("err_basic", err, 1'b0);

    // Three back-to-back states, second stalled downstream for 5 cycles.
    a = rnd_state();
    b = rnd_state();
    c = rnd_state();
    wr_cnt = 0;
    send(a);
    send(b);
    stall_cnt = 5;
    send(c);
    wait_idle();
    chk("b2b_last", last_out, shift_rows(c));
    chki("b2b_wr_en", wr_cnt, 12);
    chkb("err_b2b", err, 1'b0);

    // Reset while feeding row 2, then a fresh state must come out right.
    send(rnd_state());
    step(2);
    chki("mid_wr_row", int'(dut.wr_row), 2);
    resetn = 1'b0;
    #1;
    reset_checks("mid");
    chki("mid_shifter_row", int'(dut.u_shifter.r_q), 0);
    step(2);
    resetn = 1'b1;
    step(1);
    send(mk(SEQ_IN));
    wait_idle();
    chk("after_reset", last_out, mk(SEQ_OUT));
    chkb("err_mid", err, 1'b0);

    // Garbage on the input side while busy must be ignored.
    a = rnd_state();
    send(a);
    stall_cnt = 3;
    while (pending) begin
      in_valid = 1'($urandom_range(0, 1));
      inp = rnd_state();
      step(1);
    end
    in_valid = 1'b0;
    chk("ignored_input", last_out, shift_rows(a));

    // Random states with random gaps and random back-pressure.
    rand_rdy = 1'b1;
    repeat (25) begin
      send(rnd_state());
      step($urandom_range(0, 2));
    end
    wait_idle();
    rand_rdy = 1'b0;
    step(2);
    chkb("err_random", err, 1'b0);

    // One stray shifter write in IDLE misaligns the row counter.
    data_chk = 1'b0;
    step(2);
    force dut.sh_wr_en = 1'b1;
    step(1);
    release dut.sh_wr_en;
    step(2);
    chkb("err_stray_idle", err, 1'b0);
    send(rnd_state());
    wait_idle();
    chkb("err_misalign", err, 1'b1);
    step(5);
    chkb("err_sticky", err, 1'b1);
    do_reset();
    chkb("err_cleared", err, 1'b0);
    data_chk = 1'b1;
    send(mk(FIPS_IN));
    wait_idle();
    chk("realigned", last_out, mk(FIPS_OUT));
    chkb("err_realigned", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_enc_shiftrows_ctrl.md
# mod_enc_shiftrows_ctrl

Sequencer that applies the AES ShiftRows step to a full 16-byte state by streaming its four rows, one per cycle, through a single `mod_enc_shifter` instance. It reassembles the rotated rows into the output state. It sits in the encryption round datapath between SubBytes and MixColumns, with valid/ready handshakes on both sides. It owns the shifter's `wr_en` and keeps the shifter's internal row counter aligned with the row being fed.

## Interface
Parameters:
- `NB`, 4: bytes per row and number of rows. Fixed at 4 for AES; exists only for readability.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `resetn`  in  1  asynchronous, active-low reset. Shared with the internal shifter.
- `in_valid`  in  1  upstream state valid.
- `in_ready`  out  1  controller can accept a state.
- `inp`  in  [15:0][7:0]  input state, column-major: byte index k = 4*col + row.
- `out_valid`  out  1  shifted state available.
- `out_ready`  in  1  downstream accepts.
- `outp`  out  [15:0][7:0]  shifted state, same byte layout as `inp`.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky; shifter `done` mismatched the expected row. Cleared only by reset.

## Operation
- FSM states: IDLE, FEED, DRAIN, HOLD.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `inp` into `st_q`, clear row counter `wr_row`=0, and go to FEED.
- **FEED**
  - Each cycle, drive shifter `wr_en`=1 with `inp_sh[i] = st_q[4*i + wr_row]` for i=0..3.
  - Increment `wr_row`. After `wr_row`=3 is issued, go to DRAIN.
- **Capture**
  - Capture runs in parallel with FEED and DRAIN, with `rd_row` trailing `wr_row` by one cycle.
  - Each cycle following a write, store shifter `outp[i]` into `res_q[4*i + rd_row]`, then increment `rd_row`.
- **DRAIN**
  - No write. Capture row 3, then go to HOLD.
  - If shifter `done` is not high while capturing row 3, or is high while capturing rows 0–2, set `err`.
- **HOLD**
  - `out_valid`=1, `outp`=`res_q`.
  - On `out_ready`, go to IDLE.
- **Shifter contract**
  - Each `wr_en` edge registers `outp[i] = inp[(i+r) mod 4]` for internal row r, then advances r mod 4.
  - `done` accompanies the row-3 output.
  - The controller issues exactly 4 consecutive writes per state, which keeps r aligned with `wr_row`.
- **Input/output stability**
  - `inp` is sampled only at the accept edge; later changes are ignored.
  - `outp` is stable throughout HOLD.
- **Reset values**
  - FSM=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `err`=0, `outp`=0.
  - `st_q`, `res_q`, `wr_row`, `rd_row` all 0.
  - Shifter `wr_en`=0.

## Timing
- **Latency:** accept edge ends cycle T. Writes occur in cycles T+1..T+4, captures at the ends of cycles T+2..T+5, and `out_valid` rises in cycle T+6.
- **Throughput:** one state per 7 cycles minimum (6 cycles plus the HOLD/IDLE turnaround).
- **No overlap:** `in_ready`=0 from T+1 until the cycle after the output handshake. A new input is never accepted in the same cycle as an output handshake.
- **Downstream stall:** `out_ready` held low keeps HOLD indefinitely, with no loss and no extra shifter writes.
- **Reset mid-operation:** asserting `resetn` low in any state returns everything, including the shifter row counter, to reset values immediately. The partial state is discarded and no `out_valid` pulse occurs.
- **Idle input:** `in_valid` held high with `in_ready`=0 is ignored. `wr_en` is never asserted outside FEED.

## Structure
- Package `aes_enc_pkg`:
  - `typedef logic [7:0] byte_t`
  - `typedef byte_t [3:0] row_t`
  - `typedef byte_t [15:0] state_t`
  - FSM enum `shr_state_e` {IDLE, FEED, DRAIN, HOLD}
  - constant `AES_NB=4`
- One sub-module: `mod_enc_shifter`, instantiated once as `u_shifter`. Row gather/scatter stays inline in the controller.

## Test plan
- **Sequential state:** reset, send `inp` bytes k=00..0f → `outp` = 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b. `out_valid` arrives exactly 6 cycles after accept; `err`=0.
- **FIPS-197 vector:** state d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 → d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
- **Back-to-back with stall:** three back-to-back states with `out_ready` held low for 5 cycles on the second.
  - Each output is correct and held stable during the stall.
  - `in_ready` stays low until the handshake.
  - Exactly 12 `wr_en` pulses in total; `err`=0.
- **Reset mid-operation:** drop `resetn` in FEED with `wr_row`=2, then send a new state → correct result. This proves the shifter counter realigned; `err`=0.
- **Ignored input:** change `inp` and toggle `in_valid` during FEED/HOLD → output unaffected; no extra accept.
- **Forced misalignment:** force one extra shifter `wr_en` in IDLE via bench hook → `err` sets and stays set until reset.
